counter_stim_sequencer: RTL and testbench

- Synthesizable command sequencer that drives the control side of the up/down counter interface (load_n, ce, up_down, data_load) from a valid/ready command stream.
- Keeps a cycle-accurate reference model of the counter and checks count_out, zero and max_count every cycle.
- Reports command completion and mismatches.
- Sits opposite the counter on the same interface: it is the initiator and self-checker for on-chip and bring-up stimulus.

---
 rtl/counter_stim_sequencer.sv | 154 +++++++++++++++
 tb/tb_counter_stim_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_stim_sequencer.sv
// rtl/counter_stim_sequencer.sv - command-driven stimulus sequencer and self-checker for an up/down counter
module counter_stim_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             load_n,
    output logic             ce,
    output logic             up_down,
    output logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             zero,
    input  logic             max_count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] exp_count,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] remain;
    logic             accept;
    logic             match;
    logic             last_run;

    assign cmd_ready = rst_n && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == CHECK);
    assign last_run  = (remain == LEN_W'(1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (cmd_len != '0) ? RUN : CHECK;
                end
            end
            RUN: begin
                if (last_run) begin
                    state_nx = CHECK;
                end
            end
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Control outputs are registered; up_down and data_load keep their last value when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_n    <= 1'b1;
            ce        <= 1'b0;
            up_down   <= 1'b0;
            data_load <= '0;
            remain    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        remain <= cmd_len;
                        if (cmd_len != '0) begin
                            case (cmd_op)
                                OP_UP: begin
                                    ce      <= 1'b1;
                                    up_down <= 1'b1;
                                end
                                OP_DOWN: begin
                                    ce      <= 1'b1;
                                    up_down <= 1'b0;
                                end
                                OP_LOAD: begin
                                    load_n    <= 1'b0;
                                    data_load <= cmd_data;
                                end
                                default: begin
                                    load_n <= 1'b1;
                                    ce     <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                RUN: begin
                    remain <= remain - LEN_W'(1);
                    if (last_run) begin
                        load_n <= 1'b1;
                        ce     <= 1'b0;
                    end
                end
                default: begin
                    load_n <= 1'b1;
                    ce     <= 1'b0;
                end
            endcase
        end
    end

    assign match = (count_out == exp_count)
                && (zero == (count_out == '0))
                && (max_count == (count_out == '1));

    // The empty match branch lets an unknown match fall into the mismatch branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_count <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (!load_n) begin
                exp_count <= data_load;
            end else if (ce) begin
                exp_count <= up_down ? exp_count + WIDTH'(1) : exp_count - WIDTH'(1);
            end
            if (match) begin
            end else begin
                err <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_stim_sequencer.sv
// tb/tb_counter_stim_sequencer.sv - randomized and directed bench for counter_stim_sequencer
module tb_counter_stim_sequencer;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;
    logic             load_n;
    logic             ce;
    logic             up_down;
    logic [WIDTH-1:0] data_load;
    logic [WIDTH-1:0] count_out;
    logic             zero;
    logic             max_count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] exp_count;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    logic [WIDTH-1:0] cnt;
    logic             force_en;
    logic [WIDTH-1:0] force_val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_stim_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .load_n    (load_n),
        .ce        (ce),
        .up_down   (up_down),
        .data_load (data_load),
        .count_out (count_out),
        .zero      (zero),
        .max_count (max_count),
        .busy      (busy),
        .done      (done),
        .exp_count (exp_count),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    // Attached counter driven by the sequencer, with an override to inject bad readings.
    always @(posedge clk) begin
        if (!rst_n)       cnt <= '0;
        else if (!load_n) cnt <= data_load;
        else if (ce)      cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign count_out = force_en ? force_val : cnt;
    assign zero      = (count_out == 4'd0);
    assign max_count = (count_out == 4'hf);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Command-timeline model: t counts cycles since the accepting edge (t=1 is the first driven cycle).
    bit         started = 1'b0;
    bit         m_active;
    int         m_t;
    int         m_len;
    logic [1:0] m_op;
    logic [3:0] m_data;
    logic [3:0] m_cnt;
    logic [3:0] m_dl;
    bit         m_ud;
    bit         m_err;
    int         m_errcnt;
    bit         was_active;
    bit         in_run;

    always @(posedge clk) begin
        if (!rst_n) begin
            started  = 1'b1;
            m_active = 1'b0;
            m_t      = 0;
            m_len    = 0;
            m_cnt    = 4'd0;
            m_dl     = 4'd0;
            m_ud     = 1'b0;
            m_err    = 1'b0;
            m_errcnt = 0;
        end else if (started) begin
            if (force_en && force_val != m_cnt) begin
                m_err = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end
            if (m_active && m_t <= m_len) begin
                case (m_op)
                    2'b01:   m_cnt = m_cnt + 4'd1;
                    2'b10:   m_cnt = m_cnt - 4'd1;
                    2'b11:   m_cnt = m_data;
                    default: m_cnt = m_cnt;
                endcase
            end
            was_active = m_active;
            if (m_active) begin
                m_t++;
                if (m_t > m_len + 1) m_active = 1'b0;
            end
            if (!was_active && cmd_valid) begin
                m_active = 1'b1;
                m_t      = 1;
                m_op     = cmd_op;
                m_data   = cmd_data;
                m_len    = int'(cmd_len);
                if (cmd_len != 0) begin
                    if (cmd_op == 2'b01) m_ud = 1'b1;
                    if (cmd_op == 2'b10) m_ud = 1'b0;
                    if (cmd_op == 2'b11) m_dl = cmd_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            in_run = m_active && (m_t <= m_len);
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_active && rst_n));
            chk("busy",      32'(busy),      32'(m_active));
            chk("done",      32'(done),      32'(m_active && m_t == m_len + 1));
            chk("load_n",    32'(load_n),    32'(!(in_run && m_op == 2'b11)));
            chk("ce",        32'(ce),        32'(in_run && (m_op == 2'b01 || m_op == 2'b10)));
            chk("up_down",   32'(up_down),   32'(m_ud));
            chk("data_load", 32'(data_load), 32'(m_dl));
            chk("exp_count", 32'(exp_count), 32'(m_cnt));
            chk("err",       32'(err),       32'(m_err));
            chk("err_cnt",   32'(err_cnt),   32'(m_errcnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [7:0] l);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        cmd_len   = '0;
        force_en  = 1'b0;
        force_val = '0;
        tick();
        tick();
        chk("rst_ready",   32'(cmd_ready), 32'd0);
        chk("rst_load_n",  32'(load_n),    32'd1);
        chk("rst_exp",     32'(exp_count), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt),   32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_ready", 32'(cmd_ready), 32'd1);
        tick();

        send(2'b11, 4'd5, 8'd1);
        chk("load5_load_n", 32'(load_n), 32'd0);
        tick();
        chk("load5_done",  32'(done),      32'd1);
        chk("load5_count", 32'(count_out), 32'd5);
        chk("load5_exp",   32'(exp_count), 32'd5);
        tick();

        send(2'b01, 4'd0, 8'd3);
        chk("up3_ce", 32'(ce && up_down), 32'd1);
        repeat (3) tick();
        chk("up3_done",  32'(done),      32'd1);
        chk("up3_count", 32'(count_out), 32'd8);
        tick();

        send(2'b00, 4'd0, 8'd4);
        repeat (4) tick();
        chk("hold4_done",  32'(done),      32'd1);
        chk("hold4_count", 32'(count_out), 32'd8);
        tick();

        send(2'b11, 4'd0, 8'd1);
        tick();
        tick();
        send(2'b10, 4'd0, 8'd2);
        tick();
        chk("down_wrap15", 32'(count_out), 32'd15);
        chk("down_max",    32'(max_count), 32'd1);
        tick();
        chk("down_14",     32'(count_out), 32'd14);
        chk("down_done",   32'(done),      32'd1);
        tick();

        send(2'b11, 4'd15, 8'd1);
        tick();
        tick();
        send(2'b01, 4'd0, 8'd1);
        tick();
        chk("up_wrap0", 32'(count_out), 32'd0);
        chk("up_zero",  32'(zero),      32'd1);
        tick();

        send(2'b01, 4'd9, 8'd0);
        chk("len0_done",  32'(done),      32'd1);
        chk("len0_ce",    32'(ce),        32'd0);
        chk("len0_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("len0_ready_after", 32'(cmd_ready), 32'd1);

        send(2'b11, 4'd8, 8'd1);
        tick();
        tick();
        force_en  = 1'b1;
        force_val = 4'd3;
        tick();
        tick();
        force_en = 1'b0;
        chk("force2_err",     32'(err),     32'd1);
        chk("force2_err_cnt", 32'(err_cnt), 32'd2);
        tick();
        chk("force2_sticky",  32'(err),     32'd1);
        force_en = 1'b1;
        repeat (300) tick();
        force_en = 1'b0;
        tick();
        chk("force_saturate", 32'(err_cnt), 32'd255);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        send(2'b01, 4'd0, 8'd10);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 32'(busy),      32'd0);
        chk("abort_ce",   32'(ce),        32'd0);
        chk("abort_done", 32'(done),      32'd0);
        chk("abort_exp",  32'(exp_count), 32'd0);
        chk("abort_err",  32'(err),       32'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        tick();
        send(2'b11, 4'd7, 8'd1);
        tick();
        chk("load7_done",  32'(done),      32'd1);
        chk("load7_count", 32'(count_out), 32'd7);
        tick();

        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_data  = WIDTH'($urandom);
            cmd_len   = ($urandom_range(0, 7) == 0) ? 8'd0 : LEN_W'($urandom_range(1, 6));
            force_en  = ($urandom_range(0, 29) == 0);
            force_val = WIDTH'($urandom);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        force_en  = 1'b0;
        rst_n     = 1'b1;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
